// File: rtl/conv3_row_sequencer.sv
// Row sequencer for the 3x3 convolution datapath: streams one image row out of the
// input BRAM, holds repeat for the buffered row, then waits for downstream permission.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | streaming IMG_W pixels out of BRAM
// GAP1   | GAP idle cycles after LOAD
// REPEAT | holding conv repeat_in for REPEAT_LEN cycles
// GAP2   | at least GAP idle cycles, then wait for next_row_ok
// DONE   | one-cycle frame-end pulse
module conv3_row_sequencer #(
   parameter int IMG_W      = 482,
   parameter int IMG_H      = 482,
   parameter int ADDR_W     = 18,
   parameter int REPEAT_LEN = 3360,
   parameter int GAP        = 20
) (
   input  logic              clk,
   input  logic              Rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] cfg_base,
   input  logic              next_row_ok,
   output logic              mem_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              conv_valid_in,
   output logic              conv_repeat_in,
   output logic [15:0]       row_idx,
   output logic              busy,
   output logic              done
);

   localparam int CMAX_WG = (IMG_W > GAP) ? IMG_W : GAP;
   localparam int CMAX    = (CMAX_WG > REPEAT_LEN) ? CMAX_WG : REPEAT_LEN;
   localparam int TW      = $clog2(CMAX + 1);

   localparam logic [TW-1:0]     LD_W     = TW'(IMG_W - 1);
   localparam logic [TW-1:0]     LD_G     = TW'(GAP - 1);
   localparam logic [TW-1:0]     LD_R     = TW'((REPEAT_LEN > 0) ? REPEAT_LEN - 1 : 0);
   localparam logic [15:0]       ROW_LAST = 16'(IMG_H - 1);
   localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);

   typedef enum logic [2:0] {IDLE, LOAD, GAP1, REPEAT, GAP2, DONE} state_t;

   state_t            state, state_nx;
   logic [TW-1:0]     tmr, tmr_nx;
   logic [ADDR_W-1:0] row_ptr, ptr_nx, addr_nx;
   logic [15:0]       row_nx;
   logic              busy_nx, done_nx, post_rep;

   always_comb begin
      state_nx = state;
      tmr_nx   = (tmr == '0) ? tmr : tmr - TW'(1);
      ptr_nx   = row_ptr;
      addr_nx  = mem_addr;
      row_nx   = row_idx;
      busy_nx  = busy;
      done_nx  = 1'b0;
      post_rep = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_nx = LOAD;
               tmr_nx   = LD_W;
               ptr_nx   = cfg_base;
               addr_nx  = cfg_base;
               row_nx   = '0;
               busy_nx  = 1'b1;
            end
         end
         LOAD: begin
            if (tmr == '0) begin
               state_nx = GAP1;
               tmr_nx   = LD_G;
               ptr_nx   = row_ptr + ROW_STEP;
            end else begin
               addr_nx = mem_addr + ADDR_W'(1);
            end
         end
         GAP1: begin
            if (tmr == '0) begin
               if (REPEAT_LEN != 0) begin
                  state_nx = REPEAT;
                  tmr_nx   = LD_R;
               end else begin
                  post_rep = 1'b1;
               end
            end
         end
         REPEAT: begin
            if (tmr == '0) post_rep = 1'b1;
         end
         GAP2: begin
            if (tmr == '0 && next_row_ok) begin
               state_nx = LOAD;
               tmr_nx   = LD_W;
               addr_nx  = row_ptr;
               row_nx   = row_idx + 16'd1;
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      // Shared exit from REPEAT, or from GAP1 when there is no repeat phase.
      if (post_rep) begin
         if (row_idx == ROW_LAST) begin
            state_nx = DONE;
            done_nx  = 1'b1;
            busy_nx  = 1'b0;
         end else begin
            state_nx = GAP2;
            tmr_nx   = LD_G;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!Rst_n) begin
         state          <= IDLE;
         tmr            <= '0;
         row_ptr        <= '0;
         mem_addr       <= '0;
         mem_en         <= 1'b0;
         conv_valid_in  <= 1'b0;
         conv_repeat_in <= 1'b0;
         row_idx        <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
      end else begin
         state          <= state_nx;
         tmr            <= tmr_nx;
         row_ptr        <= ptr_nx;
         mem_addr       <= addr_nx;
         mem_en         <= (state_nx == LOAD);
         conv_valid_in  <= mem_en;
         conv_repeat_in <= (state_nx == REPEAT);
         row_idx        <= row_nx;
         busy           <= busy_nx;
         done           <= done_nx;
      end
   end

endmodule

// File: tb/tb_conv3_row_sequencer.sv
// Bench for conv3_row_sequencer: two instances (with and without a repeat phase)
// driven in lock-step and checked cycle by cycle against a row-schedule model.
module tb_conv3_row_sequencer;
   localparam int W = 8, H = 3, R = 5, G = 2, AW = 8, MAXC = 256;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start_s [2];
   logic [AW-1:0] cfg_base;
   logic          nrok;
   logic          en_o [2], val_o [2], rep_o [2], busy_o [2], done_o [2];
   logic [AW-1:0] addr_o [2];
   logic [15:0]   row_o [2];

   always #5 clk = ~clk;

   conv3_row_sequencer #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .REPEAT_LEN(R), .GAP(G)) dut_a (
      .clk(clk), .Rst_n(rst_n), .start(start_s[0]), .cfg_base(cfg_base), .next_row_ok(nrok),
      .mem_en(en_o[0]), .mem_addr(addr_o[0]), .conv_valid_in(val_o[0]),
      .conv_repeat_in(rep_o[0]), .row_idx(row_o[0]), .busy(busy_o[0]), .done(done_o[0]));

   conv3_row_sequencer #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .REPEAT_LEN(0), .GAP(G)) dut_b (
      .clk(clk), .Rst_n(rst_n), .start(start_s[1]), .cfg_base(cfg_base), .next_row_ok(nrok),
      .mem_en(en_o[1]), .mem_addr(addr_o[1]), .conv_valid_in(val_o[1]),
      .conv_repeat_in(rep_o[1]), .row_idx(row_o[1]), .busy(busy_o[1]), .done(done_o[1]));

   int tests = 0, fails = 0;
   int rl_of [2] = '{R, 0};

   // Per-cycle stimulus, model expectation and observation; flags = {en,val,rep,busy,done}
   bit            nrok_pat [MAXC];
   bit            start_pat [2][MAXC];
   logic [4:0]    e_fl [2][MAXC], o_fl [2][MAXC];
   logic [AW-1:0] e_addr [2][MAXC], o_addr [2][MAXC];
   int            e_row [2][MAXC];
   logic [15:0]   o_row [2][MAXC];
   int            done_c [2];

   // Row schedule from the behavioural rules: LOAD at ld for W cycles, GAP1, REPEAT,
   // then either DONE or a GAP2 of >= G cycles ending on the first granted cycle.
   function automatic void model(input int d, input logic [AW-1:0] base);
      int ld, post, t, rl;
      logic [AW-1:0] a;
      rl = rl_of[d];
      for (int c = 0; c < MAXC; c++) begin
         e_fl[d][c] = '0; e_addr[d][c] = '0; e_row[d][c] = -1;
      end
      ld = 1;
      for (int r = 0; r < H; r++) begin
         for (int k = 0; k < W; k++) begin
            a = base + AW'(r * W + k);
            e_fl[d][ld + k][4]     = 1'b1;
            e_addr[d][ld + k]      = a;
            e_fl[d][ld + k + 1][3] = 1'b1;
         end
         for (int k = 0; k < rl; k++) e_fl[d][ld + W + G + k][2] = 1'b1;
         post = ld + W + G + rl;
         if (r == H - 1) begin
            t = MAXC;
            done_c[d] = post;
         end else begin
            t = post + G;
            while (t < MAXC - W - R - 2 * G - 2 && !nrok_pat[t - 1]) t++;
         end
         for (int c = ld; c < t; c++) e_row[d][c] = r;
         ld = t;
      end
      for (int c = 1; c < done_c[d]; c++) e_fl[d][c][1] = 1'b1;
      e_fl[d][done_c[d]][0] = 1'b1;
   endfunction

   function automatic void clear_pats();
      for (int c = 0; c < MAXC; c++) begin
         nrok_pat[c] = 1'b1; start_pat[0][c] = 1'b0; start_pat[1][c] = 1'b0;
      end
      start_pat[0][0] = 1'b1; start_pat[1][0] = 1'b1;
   endfunction

   // Entered right after a clock edge (cycle 0); records outputs for cycles 1..ncyc-1.
   task automatic run_frame(input logic [AW-1:0] base, input int ncyc, input int rst_at);
      cfg_base = base; nrok = nrok_pat[0];
      start_s[0] = start_pat[0][0]; start_s[1] = start_pat[1][0];
      for (int c = 1; c < ncyc; c++) begin
         @(posedge clk); #1;
         cfg_base = AW'($urandom);
         nrok = nrok_pat[c];
         start_s[0] = start_pat[0][c]; start_s[1] = start_pat[1][c];
         if (c == rst_at) rst_n = 1'b0;
         for (int d = 0; d < 2; d++) begin
            o_fl[d][c]   = {en_o[d], val_o[d], rep_o[d], busy_o[d], done_o[d]};
            o_addr[d][c] = addr_o[d];
            o_row[d][c]  = row_o[d];
         end
      end
      start_s[0] = 1'b0; start_s[1] = 1'b0; rst_n = 1'b1;
   endtask

   function automatic int frame_len();
      return ((done_c[0] > done_c[1]) ? done_c[0] : done_c[1]) + 4;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0; start_s[0] = 1'b0; start_s[1] = 1'b0; nrok = 1'b0; cfg_base = '0;
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         tests++;
         if ({en_o[d], val_o[d], rep_o[d], busy_o[d], done_o[d], addr_o[d], row_o[d]} !== '0) begin
            fails++;
            $display("FAIL reset dut%0d got flags %b addr %0d row %0d want all 0", d,
                     {en_o[d], val_o[d], rep_o[d], busy_o[d], done_o[d]}, addr_o[d], row_o[d]);
         end
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_nominal();
      int n;
      clear_pats();
      model(0, 8'd100); model(1, 8'd100);
      n = frame_len();
      run_frame(8'd100, n, -1);
      for (int d = 0; d < 2; d++)
         for (int c = 1; c < n; c++) begin
            tests++;
            if (o_fl[d][c] !== e_fl[d][c]) begin fails++;
               $display("FAIL nominal flags dut%0d cyc %0d got %b want %b", d, c, o_fl[d][c], e_fl[d][c]); end
            if (e_fl[d][c][4]) begin tests++;
               if (o_addr[d][c] !== e_addr[d][c]) begin fails++;
                  $display("FAIL nominal addr dut%0d cyc %0d got %0d want %0d", d, c, o_addr[d][c], e_addr[d][c]); end end
            if (e_row[d][c] >= 0) begin tests++;
               if (o_row[d][c] !== 16'(e_row[d][c])) begin fails++;
                  $display("FAIL nominal row dut%0d cyc %0d got %0d want %0d", d, c, o_row[d][c], e_row[d][c]); end end
         end
      tests++;
      if (o_fl[0][18][4] !== 1'b1 || o_fl[0][17][4] !== 1'b0 || o_addr[0][18] !== 8'd108) begin fails++;
         $display("FAIL row1_load_at_18 got en17=%b en18=%b addr=%0d want 0 1 108", o_fl[0][17][4], o_fl[0][18][4], o_addr[0][18]); end
      tests++;
      if (o_fl[0][35][4] !== 1'b1 || o_addr[0][35] !== 8'd116 || o_addr[0][42] !== 8'd123) begin fails++;
         $display("FAIL row2_load_at_35 got en=%b addr35=%0d addr42=%0d want 1 116 123", o_fl[0][35][4], o_addr[0][35], o_addr[0][42]); end
      tests++;
      if (o_fl[0][50][1:0] !== 2'b01 || o_fl[0][49][1:0] !== 2'b10) begin fails++;
         $display("FAIL done_at_50 got busy,done c49=%b c50=%b want 10 01", o_fl[0][49][1:0], o_fl[0][50][1:0]); end
      tests++;
      if (o_fl[1][13][4] !== 1'b1 || o_fl[1][12][4] !== 1'b0 || o_addr[1][13] !== 8'd108) begin fails++;
         $display("FAIL norepeat_row1_at_13 got en12=%b en13=%b addr=%0d want 0 1 108", o_fl[1][12][4], o_fl[1][13][4], o_addr[1][13]); end
   endtask

   task automatic test_backpressure();
      int n;
      clear_pats();
      for (int c = 0; c < 30; c++) nrok_pat[c] = 1'b0;
      model(0, 8'd100); model(1, 8'd100);
      n = frame_len();
      run_frame(8'd100, n, -1);
      for (int d = 0; d < 2; d++)
         for (int c = 1; c < n; c++) begin
            tests++;
            if (o_fl[d][c] !== e_fl[d][c]) begin fails++;
               $display("FAIL backpressure flags dut%0d cyc %0d got %b want %b", d, c, o_fl[d][c], e_fl[d][c]); end
            if (e_fl[d][c][4]) begin tests++;
               if (o_addr[d][c] !== e_addr[d][c]) begin fails++;
                  $display("FAIL backpressure addr dut%0d cyc %0d got %0d want %0d", d, c, o_addr[d][c], e_addr[d][c]); end end
         end
      for (int c = 16; c <= 30; c++) begin
         tests++;
         if (o_fl[0][c][4] !== 1'b0) begin fails++;
            $display("FAIL backpressure_hold cyc %0d got mem_en %b want 0", c, o_fl[0][c][4]); end
      end
      tests++;
      if (o_fl[0][31][4] !== 1'b1 || o_addr[0][31] !== 8'd108) begin fails++;
         $display("FAIL backpressure_release got en=%b addr=%0d want 1 108", o_fl[0][31][4], o_addr[0][31]); end
   endtask

   task automatic test_start_busy();
      int n;
      clear_pats();
      model(0, 8'd250); model(1, 8'd250);
      for (int d = 0; d < 2; d++) begin
         start_pat[d][5] = 1'b1;
         start_pat[d][done_c[d]] = 1'b1;
      end
      n = frame_len();
      run_frame(8'd250, n, -1);
      for (int d = 0; d < 2; d++)
         for (int c = 1; c < n; c++) begin
            tests++;
            if (o_fl[d][c] !== e_fl[d][c]) begin fails++;
               $display("FAIL start_busy flags dut%0d cyc %0d got %b want %b", d, c, o_fl[d][c], e_fl[d][c]); end
            if (e_fl[d][c][4]) begin tests++;
               if (o_addr[d][c] !== e_addr[d][c]) begin fails++;
                  $display("FAIL start_busy addr dut%0d cyc %0d got %0d want %0d", d, c, o_addr[d][c], e_addr[d][c]); end end
            if (e_row[d][c] >= 0) begin tests++;
               if (o_row[d][c] !== 16'(e_row[d][c])) begin fails++;
                  $display("FAIL start_busy row dut%0d cyc %0d got %0d want %0d", d, c, o_row[d][c], e_row[d][c]); end end
         end
   endtask

   task automatic test_mid_reset();
      clear_pats();
      run_frame(8'd100, 13, 11);
      for (int d = 0; d < 2; d++) begin
         tests++;
         if ({o_fl[d][12], o_addr[d][12], o_row[d][12]} !== '0) begin fails++;
            $display("FAIL mid_reset dut%0d cyc 12 got flags %b addr %0d row %0d want all 0",
                     d, o_fl[d][12], o_addr[d][12], o_row[d][12]); end
      end
      @(posedge clk); #1;
      test_nominal();
   endtask

   task automatic test_random();
      int n;
      logic [AW-1:0] base;
      for (int it = 0; it < 6; it++) begin
         clear_pats();
         base = AW'($urandom);
         for (int c = 0; c < MAXC; c++) nrok_pat[c] = ($urandom_range(0, 2) != 0);
         model(0, base); model(1, base);
         for (int d = 0; d < 2; d++)
            for (int k = 0; k < 3; k++) start_pat[d][$urandom_range(1, done_c[d])] = 1'b1;
         n = frame_len();
         run_frame(base, n, -1);
         for (int d = 0; d < 2; d++)
            for (int c = 1; c < n; c++) begin
               tests++;
               if (o_fl[d][c] !== e_fl[d][c]) begin fails++;
                  $display("FAIL random%0d flags dut%0d cyc %0d got %b want %b", it, d, c, o_fl[d][c], e_fl[d][c]); end
               if (e_fl[d][c][4]) begin tests++;
                  if (o_addr[d][c] !== e_addr[d][c]) begin fails++;
                     $display("FAIL random%0d addr dut%0d cyc %0d got %0d want %0d", it, d, c, o_addr[d][c], e_addr[d][c]); end end
               if (e_row[d][c] >= 0) begin tests++;
                  if (o_row[d][c] !== 16'(e_row[d][c])) begin fails++;
                     $display("FAIL random%0d row dut%0d cyc %0d got %0d want %0d", it, d, c, o_row[d][c], e_row[d][c]); end end
            end
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_backpressure();
      test_start_busy();
      test_mid_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
